// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: Moore state register plus decoded datapath controls.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       InstrRetired,
    output logic       IllegalInstr
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_UPPER    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t state_q;
    state_t state_next;
    logic   illegal_q;

    // State register; reset lands in FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Illegal-instruction flag: set on the edge that enters TRAP, held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_next == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and control decode; every control defaults to 0.
    always_comb begin
        state_next   = state_q;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ImmSrc       = 3'b000;
        ALUOp        = 2'b00;
        InstrRetired = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ResultSrc  = 2'b10;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target OldPC+imm is precomputed here into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_AUIPC, OP_LUI:  state_next = S_UPPER;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (opcode == OP_LOAD) ? 3'b000 : 3'b001;
                state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady) begin
                    InstrRetired = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUOp        = 2'b01;
                PCWrite      = BranchTaken;
                InstrRetired = 1'b1;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target while the ALU forms OldPC+4 for rd.
                PCWrite    = 1'b1;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_LINK;
            end
            S_LINK: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                state_next   = S_FETCH;
            end
            S_UPPER: begin
                ALUSrcA    = (opcode == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b100;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign State        = STATE_W'(state_q);
    assign IllegalInstr = illegal_q;

endmodule
